// File: rtl/fp_pkg.sv
// Shared FP definitions: rounding-mode encodings, binary32 constants,
// the integer-to-float pipeline stage records and the rounding decision.
package fp_pkg;

    localparam int XLEN   = 32;
    localparam int BIAS   = 127;
    localparam int MANT_W = 23;

    localparam logic [2:0] RM_RNE = 3'b000;
    localparam logic [2:0] RM_RTZ = 3'b001;
    localparam logic [2:0] RM_RDN = 3'b010;
    localparam logic [2:0] RM_RUP = 3'b011;
    localparam logic [2:0] RM_RMM = 3'b100;
    localparam logic [2:0] RM_DYN = 3'b111;

    // S1 record: sign-stripped operand with its resolved rounding mode
    typedef struct packed {
        logic             sign;
        logic [XLEN-1:0]  mag;
        logic [2:0]       rm;
        logic             ill;
    } s1_t;

    // S2 record: normalised magnitude (bit 31 set unless zero) and biased exponent
    typedef struct packed {
        logic             sign;
        logic [XLEN-1:0]  norm;
        logic [7:0]       exp;
        logic [2:0]       rm;
        logic             ill;
    } s2_t;

    // 101, 110 and 111 are not usable as an effective rounding mode
    function automatic logic rm_reserved(input logic [2:0] rm);
        return (rm == 3'b101) || (rm == 3'b110) || (rm == 3'b111);
    endfunction

    // Increment decision from kept lsb, guard and sticky
    function automatic logic round_up(input logic [2:0] rm, input logic sign,
                                      input logic lsb, input logic g, input logic s);
        logic up;
        case (rm)
            RM_RNE:  up = g & (s | lsb);
            RM_RTZ:  up = 1'b0;
            RM_RDN:  up = sign & (g | s);
            RM_RUP:  up = ~sign & (g | s);
            RM_RMM:  up = g;
            default: up = 1'b0;
        endcase
        return up;
    endfunction

endpackage

// File: rtl/lzc32.sv
// 32-bit leading-zero counter. Result is 0..31 for non-zero input and 32
// for zero, so bit 5 doubles as the zero flag.
module lzc32 (
    input  logic [31:0] x,
    output logic [5:0]  cnt
);

    // scan upward so the most significant set bit wins
    always_comb begin
        cnt = 6'd32;
        for (int i = 0; i < 32; i++) begin
            if (x[i]) cnt = 6'(31 - i);
        end
    end

endmodule

// File: rtl/i2f_pipe.sv
// FCVT.S.W / FCVT.S.WU: 3-stage elastic integer -> binary32 converter.
// S1 strips the sign, S2 normalises, S3 rounds and holds the result until taken.
module i2f_pipe
    import fp_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] a,
    input  logic        is_unsigned,
    input  logic [2:0]  frm,
    input  logic [2:0]  dyn_frm,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] d,
    output logic        NX,
    output logic        illegal_rm
);

    logic [3:1] vld_pipe;
    logic       rdy1, rdy2, rdy3;

    s1_t        s1_q, s1_n;
    s2_t        s2_q, s2_n;
    logic [5:0] lz;

    logic [2:0] eff_rm;
    logic       in_sign;

    logic [23:0] keep;
    logic        g_bit, s_bit, up;
    logic        carry;
    logic [22:0] mant;
    logic [7:0]  exp_r;
    logic        zero;
    logic [31:0] d_n;
    logic        nx_n;

    // a stage can load when it is empty or its content moves on this cycle
    assign rdy3      = ~vld_pipe[3] | out_ready;
    assign rdy2      = ~vld_pipe[2] | rdy3;
    assign rdy1      = ~vld_pipe[1] | rdy2;
    assign in_ready  = rdy1;
    assign out_valid = vld_pipe[3];

    // S1: resolve rounding mode, take magnitude (-0x80000000 wraps to 2^31 unsigned)
    always_comb begin
        eff_rm   = (frm == RM_DYN) ? dyn_frm : frm;
        in_sign  = a[31] & ~is_unsigned;
        s1_n     = '0;
        s1_n.sign = in_sign;
        s1_n.mag  = in_sign ? (~a + 32'd1) : a;
        s1_n.rm   = eff_rm;
        s1_n.ill  = rm_reserved(eff_rm);
    end

    lzc32 u_lzc (
        .x   (s1_q.mag),
        .cnt (lz)
    );

    // S2: normalise so the leading one lands on bit 31
    always_comb begin
        s2_n      = '0;
        s2_n.sign = s1_q.sign;
        s2_n.norm = s1_q.mag << lz[4:0];
        s2_n.exp  = 8'(BIAS + XLEN - 1) - {2'b00, lz};
        s2_n.rm   = s1_q.rm;
        s2_n.ill  = s1_q.ill;
    end

    // S3: round to 24 bits; a carry out of the fraction bumps the exponent
    always_comb begin
        zero         = ~s2_q.norm[31];
        keep         = s2_q.norm[31:8];
        g_bit        = s2_q.norm[7];
        s_bit        = |s2_q.norm[6:0];
        up           = round_up(s2_q.rm, s2_q.sign, keep[0], g_bit, s_bit);
        {carry, mant} = {1'b0, keep[22:0]} + {23'd0, up};
        exp_r        = s2_q.exp + {7'd0, carry};
        d_n          = {s2_q.sign, exp_r, mant};
        nx_n         = g_bit | s_bit;
        if (s2_q.ill || zero) begin
            d_n  = '0;
            nx_n = 1'b0;
        end
    end

    // stage valid bits advance along the elastic chain
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_pipe <= '0;
        end else begin
            if (rdy1) vld_pipe[1] <= in_valid;
            if (rdy2) vld_pipe[2] <= vld_pipe[1];
            if (rdy3) vld_pipe[3] <= vld_pipe[2];
        end
    end

    // stage payload registers load only with a valid op moving in
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_q       <= '0;
            s2_q       <= '0;
            d          <= '0;
            NX         <= 1'b0;
            illegal_rm <= 1'b0;
        end else begin
            if (rdy1 && in_valid)    s1_q <= s1_n;
            if (rdy2 && vld_pipe[1]) s2_q <= s2_n;
            if (rdy3 && vld_pipe[2]) begin
                d          <= d_n;
                NX         <= nx_n;
                illegal_rm <= s2_q.ill;
            end
        end
    end

endmodule

// File: tb/tb_i2f_pipe.sv
// Directed bench for i2f_pipe: rounding vectors, streaming, backpressure, reset.
module tb_i2f_pipe;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] a;
    logic        is_unsigned;
    logic [2:0]  frm;
    logic [2:0]  dyn_frm;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] d;
    logic        NX;
    logic        illegal_rm;

    int n_cmp  = 0;
    int n_fail = 0;
    int cyc    = 0;

    logic [31:0] oq_d[$];
    logic        oq_nx[$];
    logic        oq_ill[$];
    int          oq_cyc[$];
    int          iq_cyc[$];

    typedef struct packed {
        logic [31:0] a;
        logic        uns;
        logic [2:0]  frm;
        logic [2:0]  dyn;
        logic [31:0] ed;
        logic        enx;
        logic        eill;
    } vec_t;

    i2f_pipe dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .a           (a),
        .is_unsigned (is_unsigned),
        .frm         (frm),
        .dyn_frm     (dyn_frm),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .d           (d),
        .NX          (NX),
        .illegal_rm  (illegal_rm)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // record handshakes away from the active edge
    always @(negedge clk) begin
        if (!rst) begin
            if (in_valid && in_ready) iq_cyc.push_back(cyc);
            if (out_valid && out_ready) begin
                oq_d.push_back(d);
                oq_nx.push_back(NX);
                oq_ill.push_back(illegal_rm);
                oq_cyc.push_back(cyc);
            end
        end
    end

    task automatic clear_q();
        oq_d.delete(); oq_nx.delete(); oq_ill.delete(); oq_cyc.delete(); iq_cyc.delete();
    endtask

    task automatic wait_outputs(input int n);
        for (int k = 0; k < 40 && oq_d.size() < n; k++) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        a = '0; is_unsigned = 1'b0; frm = 3'b000; dyn_frm = 3'b000;
        repeat (3) @(posedge clk);
        #1;
        n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset.out_valid got=%b exp=0", out_valid); end
        n_cmp++; if (d !== 32'h0) begin n_fail++; $display("FAIL reset.d got=%h exp=00000000", d); end
        n_cmp++; if (NX !== 1'b0) begin n_fail++; $display("FAIL reset.NX got=%b exp=0", NX); end
        n_cmp++; if (illegal_rm !== 1'b0) begin n_fail++; $display("FAIL reset.illegal_rm got=%b exp=0", illegal_rm); end
        rst = 1'b0;
        @(posedge clk); #1;
        n_cmp++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset.in_ready got=%b exp=1", in_ready); end
    endtask

    task automatic test_rounding();
        vec_t v[20];
        v[0]  = '{32'h7FFFFFFF, 1'b0, 3'b000, 3'b000, 32'h4F000000, 1'b1, 1'b0};
        v[1]  = '{32'h7FFFFFFF, 1'b0, 3'b001, 3'b000, 32'h4EFFFFFF, 1'b1, 1'b0};
        v[2]  = '{32'h01000001, 1'b0, 3'b000, 3'b000, 32'h4B800000, 1'b1, 1'b0};
        v[3]  = '{32'h01000001, 1'b0, 3'b011, 3'b000, 32'h4B800001, 1'b1, 1'b0};
        v[4]  = '{32'h01000001, 1'b0, 3'b100, 3'b000, 32'h4B800001, 1'b1, 1'b0};
        v[5]  = '{32'hFEFFFFFF, 1'b0, 3'b010, 3'b000, 32'hCB800001, 1'b1, 1'b0};
        v[6]  = '{32'hFFFFFFFD, 1'b0, 3'b000, 3'b000, 32'hC0400000, 1'b0, 1'b0};
        v[7]  = '{32'h80000000, 1'b0, 3'b000, 3'b000, 32'hCF000000, 1'b0, 1'b0};
        v[8]  = '{32'hFFFFFFFF, 1'b1, 3'b000, 3'b000, 32'h4F800000, 1'b1, 1'b0};
        v[9]  = '{32'h00000000, 1'b0, 3'b000, 3'b000, 32'h00000000, 1'b0, 1'b0};
        v[10] = '{32'h7FFFFFFF, 1'b0, 3'b101, 3'b000, 32'h00000000, 1'b0, 1'b1};
        v[11] = '{32'h7FFFFFFF, 1'b0, 3'b111, 3'b001, 32'h4EFFFFFF, 1'b1, 1'b0};
        v[12] = '{32'h7FFFFFFF, 1'b0, 3'b111, 3'b111, 32'h00000000, 1'b0, 1'b1};
        v[13] = '{32'hFEFFFFFF, 1'b0, 3'b011, 3'b000, 32'hCB800000, 1'b1, 1'b0};
        v[14] = '{32'h00000000, 1'b0, 3'b010, 3'b000, 32'h00000000, 1'b0, 1'b0};
        v[15] = '{32'h01000003, 1'b0, 3'b000, 3'b000, 32'h4B800002, 1'b1, 1'b0};
        v[16] = '{32'hFFFFFFFF, 1'b0, 3'b000, 3'b000, 32'hBF800000, 1'b0, 1'b0};
        v[17] = '{32'hFFFFFFFF, 1'b1, 3'b001, 3'b000, 32'h4F7FFFFF, 1'b1, 1'b0};
        v[18] = '{32'h00000005, 1'b0, 3'b110, 3'b000, 32'h00000000, 1'b0, 1'b1};
        v[19] = '{32'h00000005, 1'b1, 3'b111, 3'b000, 32'h40A00000, 1'b0, 1'b0};
        for (int i = 0; i < 20; i++) begin
            clear_q();
            out_ready = 1'b1;
            in_valid = 1'b1; a = v[i].a; is_unsigned = v[i].uns; frm = v[i].frm; dyn_frm = v[i].dyn;
            @(posedge clk); #1;
            in_valid = 1'b0;
            wait_outputs(1);
            n_cmp++;
            if (oq_d.size() != 1 || iq_cyc.size() != 1) begin
                n_fail++; $display("FAIL vec%0d.count got=%0d exp=1", i, oq_d.size());
            end else begin
                if (oq_d[0] !== v[i].ed) begin n_fail++; $display("FAIL vec%0d.d got=%h exp=%h", i, oq_d[0], v[i].ed); end
                n_cmp++; if (oq_nx[0] !== v[i].enx) begin n_fail++; $display("FAIL vec%0d.NX got=%b exp=%b", i, oq_nx[0], v[i].enx); end
                n_cmp++; if (oq_ill[0] !== v[i].eill) begin n_fail++; $display("FAIL vec%0d.illegal_rm got=%b exp=%b", i, oq_ill[0], v[i].eill); end
                n_cmp++; if (oq_cyc[0] - iq_cyc[0] != 3) begin n_fail++; $display("FAIL vec%0d.latency got=%0d exp=3", i, oq_cyc[0] - iq_cyc[0]); end
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] ev[8];
        ev = '{32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000,
               32'h40A00000, 32'h40C00000, 32'h40E00000, 32'h41000000};
        clear_q();
        out_ready = 1'b1; is_unsigned = 1'b0; frm = 3'b000;
        for (int i = 0; i < 8; i++) begin
            in_valid = 1'b1; a = 32'(i + 1);
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        wait_outputs(8);
        repeat (4) @(posedge clk);
        #1;
        n_cmp++;
        if (oq_d.size() != 8 || iq_cyc.size() != 8) begin
            n_fail++; $display("FAIL b2b.count got_in=%0d got_out=%0d exp=8", iq_cyc.size(), oq_d.size());
        end else begin
            for (int i = 0; i < 8; i++) begin
                n_cmp++; if (oq_d[i] !== ev[i]) begin n_fail++; $display("FAIL b2b.d%0d got=%h exp=%h", i, oq_d[i], ev[i]); end
                n_cmp++; if (oq_cyc[i] - iq_cyc[i] != 3) begin n_fail++; $display("FAIL b2b.lat%0d got=%0d exp=3", i, oq_cyc[i] - iq_cyc[i]); end
                n_cmp++; if (oq_cyc[i] != oq_cyc[0] + i) begin n_fail++; $display("FAIL b2b.rate%0d got=%0d exp=%0d", i, oq_cyc[i], oq_cyc[0] + i); end
            end
        end
    endtask

    task automatic test_backpressure();
        logic [31:0] ev[8];
        int   idx = 0;
        int   stall_acc = 0;
        logic acc;
        ev = '{32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000,
               32'h40A00000, 32'h40C00000, 32'h40E00000, 32'h41000000};
        clear_q();
        out_ready = 1'b0; is_unsigned = 1'b0; frm = 3'b000;
        for (int t = 0; t < 60 && idx < 8; t++) begin
            in_valid = 1'b1; a = 32'(idx + 1);
            if (t == 4) out_ready = 1'b1;
            @(negedge clk);
            acc = in_ready;
            if (t < 4 && acc) stall_acc++;
            if (t == 3) begin
                n_cmp++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL bp.in_ready_full got=%b exp=0", in_ready); end
                n_cmp++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL bp.out_valid_held got=%b exp=1", out_valid); end
                n_cmp++; if (d !== 32'h3F800000) begin n_fail++; $display("FAIL bp.d_held got=%h exp=3f800000", d); end
            end
            @(posedge clk); #1;
            if (acc) idx++;
        end
        in_valid = 1'b0;
        wait_outputs(8);
        repeat (5) @(posedge clk);
        #1;
        n_cmp++; if (stall_acc != 3) begin n_fail++; $display("FAIL bp.accepts_before_full got=%0d exp=3", stall_acc); end
        n_cmp++;
        if (oq_d.size() != 8) begin
            n_fail++; $display("FAIL bp.count got=%0d exp=8", oq_d.size());
        end else begin
            for (int i = 0; i < 8; i++) begin
                n_cmp++; if (oq_d[i] !== ev[i]) begin n_fail++; $display("FAIL bp.d%0d got=%h exp=%h", i, oq_d[i], ev[i]); end
            end
        end
    endtask

    task automatic test_reset_midstream();
        clear_q();
        out_ready = 1'b0; is_unsigned = 1'b0; frm = 3'b000;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1; a = 32'h7FFFFFFF - 32'(i);
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        n_cmp++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL rstmid.pre_out_valid got=%b exp=1", out_valid); end
        rst = 1'b1;
        @(posedge clk); #1;
        n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rstmid.out_valid got=%b exp=0", out_valid); end
        n_cmp++; if (d !== 32'h0) begin n_fail++; $display("FAIL rstmid.d got=%h exp=00000000", d); end
        rst = 1'b0;
        out_ready = 1'b1;
        repeat (8) @(posedge clk);
        #1;
        n_cmp++; if (oq_d.size() != 0) begin n_fail++; $display("FAIL rstmid.leaked got=%0d exp=0", oq_d.size()); end
    endtask

    initial begin
        test_reset();
        test_rounding();
        test_back_to_back();
        test_backpressure();
        test_reset_midstream();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
